// File: rtl/seq_signed_multiplier.sv
// Sequential two's-complement shift-add multiplier, one partial product per clock.
// Optional overflow flag enabled by defining SEQ_MUL_OVF_EN.
module seq_signed_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t         state;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] acc;
  logic           x;
  logic [CW-1:0]  cnt;

  logic             sub;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] next_product;

  // The last iteration weighs the multiplier's sign bit negatively, so it subtracts M.
  always_comb begin
    sub    = (cnt == LAST);
    addend = {m_reg[WIDTH-1], m_reg} ^ {(WIDTH+1){sub}};
    sum    = {x, acc};
    if (q_reg[0])
      sum = {x, acc} + addend + {{WIDTH{1'b0}}, sub};
    next_product = {sum, q_reg[WIDTH-1:1]};
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state   <= IDLE;
      m_reg   <= '0;
      q_reg   <= '0;
      acc     <= '0;
      x       <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m_reg <= A;
            q_reg <= B;
            acc   <= '0;
            x     <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          x     <= sum[WIDTH];
          acc   <= sum[WIDTH:1];
          q_reg <= {sum[0], q_reg[WIDTH-1:1]};
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= next_product;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_MUL_OVF_EN
  logic ovf_next;

  // Out of range when the bits above the WIDTH-bit sign position disagree.
  assign ovf_next = ~((&next_product[2*WIDTH-1:WIDTH-1]) | ~(|next_product[2*WIDTH-1:WIDTH-1]));

  always_ff @(posedge Clk) begin
    if (!Reset_n)
      ovf <= 1'b0;
    else if (state == RUN && cnt == LAST)
      ovf <= ovf_next;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Self-checking bench for seq_signed_multiplier at WIDTH 8, 4 and 16.
// Expected ovf follows SEQ_MUL_OVF_EN as compiled.
module tb_seq_signed_multiplier;

`ifdef SEQ_MUL_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        start8, busy8, done8, ovf8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;

  logic        start4, busy4, done4, ovf4;
  logic [3:0]  a4, b4;
  logic [7:0]  prod4;

  logic        start16, busy16, done16, ovf16;
  logic [15:0] a16, b16;
  logic [31:0] prod16;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int dones8 = 0, dones4 = 0, dones16 = 0;
  int acc8 = 0, acc4 = 0, acc16 = 0;

  seq_signed_multiplier #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset_n(rst_n), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .product(prod8), .ovf(ovf8)
  );

  seq_signed_multiplier #(.WIDTH(4)) dut4 (
    .Clk(clk), .Reset_n(rst_n), .start(start4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .product(prod4), .ovf(ovf4)
  );

  seq_signed_multiplier #(.WIDTH(16)) dut16 (
    .Clk(clk), .Reset_n(rst_n), .start(start16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .product(prod16), .ovf(ovf16)
  );

  // Count every done pulse seen, independent of the directed steps.
  always @(negedge clk) begin
    if (done8)  dones8++;
    if (done4)  dones4++;
    if (done16) dones16++;
  end

  function automatic bit ovf_model(input longint p, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    return OVF_EN && (p > hi || p < lo);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full WIDTH=8 operation with timing checks; disturb >= 0 pokes start/A/B during RUN.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input int disturb, input string tag);
    longint p;
    logic [15:0] e;
    int cyc, busy_n;
    p = longint'($signed(a)) * longint'($signed(b));
    e = p[15:0];
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    acc8++;
    cyc = 0;
    busy_n = 0;
    while (!done8 && cyc < 40) begin
      if (busy8) busy_n++;
      if (cyc == disturb) begin
        start8 = 1'b1; a8 = ~a; b8 = b + 8'd1;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start8 = 1'b0;
    checkOutput({tag, " latency"}, 64'(cyc), 64'd8);
    checkOutput({tag, " busy cycles"}, 64'(busy_n), 64'd8);
    checkOutput({tag, " busy in done"}, 64'(busy8), 64'd0);
    checkOutput({tag, " product"}, 64'(prod8), 64'(e));
    checkOutput({tag, " ovf"}, 64'(ovf8), 64'(ovf_model(p, 8)));
    @(posedge clk); #1;
    checkOutput({tag, " done pulse width"}, 64'(done8), 64'd0);
    checkOutput({tag, " product held"}, 64'(prod8), 64'(e));
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b);
    longint p;
    logic [7:0] e;
    int cyc;
    p = longint'($signed(a)) * longint'($signed(b));
    e = p[7:0];
    @(negedge clk);
    a4 = a; b4 = b; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    acc4++;
    cyc = 0;
    while (!done4 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput($sformatf("w4 %0d*%0d latency", $signed(a), $signed(b)), 64'(cyc), 64'd4);
    checkOutput($sformatf("w4 %0d*%0d product", $signed(a), $signed(b)), 64'(prod4), 64'(e));
    checkOutput($sformatf("w4 %0d*%0d ovf", $signed(a), $signed(b)), 64'(ovf4), 64'(ovf_model(p, 4)));
    @(posedge clk); #1;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b);
    longint p;
    logic [31:0] e;
    int cyc;
    p = longint'($signed(a)) * longint'($signed(b));
    e = p[31:0];
    @(negedge clk);
    a16 = a; b16 = b; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    acc16++;
    cyc = 0;
    while (!done16 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput($sformatf("w16 %0h*%0h done", a, b), 64'(done16), 64'd1);
    checkOutput($sformatf("w16 %0h*%0h product", a, b), 64'(prod16), 64'(e));
    checkOutput($sformatf("w16 %0h*%0h ovf", a, b), 64'(ovf16), 64'(ovf_model(p, 16)));
    @(posedge clk); #1;
  endtask

  logic [7:0] av [30];
  logic [7:0] bv [30];

  initial begin
    longint p;
    logic [7:0] idx;
    int off, d0, seen;

    rst_n = 1'b0;
    start8 = 1'b0;  a8 = '0;  b8 = '0;
    start4 = 1'b0;  a4 = '0;  b4 = '0;
    start16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", 64'(busy8), 64'd0);
    checkOutput("reset done", 64'(done8), 64'd0);
    checkOutput("reset product", 64'(prod8), 64'd0);
    checkOutput("reset ovf", 64'(ovf8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    applyStimulus(8'd7,   8'hFD, -1, "7*-3");
    applyStimulus(8'h80,  8'h80, -1, "-128*-128");
    applyStimulus(8'd127, 8'd1,  -1, "127*1");
    applyStimulus(8'd16,  8'd16, -1, "16*16");
    applyStimulus(8'd0,   8'hFF, -1, "0*-1");
    applyStimulus(8'hFF,  8'd0,  -1, "-1*0");
    applyStimulus(8'hFF,  8'hFF, -1, "-1*-1");
    applyStimulus(8'h80,  8'd127, -1, "-128*127");
    for (int i = 0; i < 6; i++)
      applyStimulus(8'($urandom), 8'($urandom), -1, $sformatf("w8 random %0d", i));

    // Start re-pulsed with new operands at RUN cycle 3 must be ignored.
    applyStimulus(8'd45, 8'hE7, 3, "ignore start in run");

    // Start held high: accepts every 10 cycles using operands at each accept edge.
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom);
      av[c] = a8; bv[c] = b8;
      start8 = 1'b1;
      @(posedge clk); #1;
      if (c % 10 == 8) begin
        p = longint'($signed(av[c-8])) * longint'($signed(bv[c-8]));
        checkOutput($sformatf("held start done %0d", c / 10), 64'(done8), 64'd1);
        checkOutput($sformatf("held start product %0d", c / 10), 64'(prod8), 64'(p[15:0]));
        if (done8) seen++;
      end else if (done8) begin
        checkOutput($sformatf("held start stray done at %0d", c), 64'(done8), 64'd0);
      end
    end
    @(negedge clk);
    start8 = 1'b0;
    acc8 += 3;
    checkOutput("held start result count", 64'(seen), 64'd3);
    repeat (2) @(posedge clk);

    // Reset in the middle of a run aborts without a done pulse.
    applyStimulus(8'd100, 8'd3, -1, "pre-abort");
    @(negedge clk);
    a8 = 8'd5; b8 = 8'd9; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    d0 = dones8;
    @(posedge clk); #1;
    checkOutput("abort busy", 64'(busy8), 64'd0);
    checkOutput("abort done", 64'(done8), 64'd0);
    checkOutput("abort product", 64'(prod8), 64'd0);
    checkOutput("abort ovf", 64'(ovf8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("no done after abort", 64'(dones8), 64'(d0));
    applyStimulus(8'hFB, 8'd9, -1, "after abort");

    // WIDTH=4: every operand pair, visited in a random permutation.
    off = int'($urandom_range(0, 255));
    for (int i = 0; i < 256; i++) begin
      idx = 8'((i * 37 + off) & 255);
      run4(idx[7:4], idx[3:0]);
    end

    // WIDTH=16: corner pairs then random ones.
    run16(16'h8000, 16'h8000);
    run16(16'h7FFF, 16'h8000);
    run16(16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 1000; i++)
      run16(16'($urandom), 16'($urandom));

    repeat (3) @(posedge clk);
    #1;
    checkOutput("w8 done count", 64'(dones8), 64'(acc8));
    checkOutput("w4 done count", 64'(dones4), 64'(acc4));
    checkOutput("w16 done count", 64'(dones16), 64'(acc16));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
